cfb_stream_engine: RTL and testbench

Synthesizable AES-128 cipher-feedback (CFB) mode engine with a parameterised segment width, which sets the CFB-s bit count. It supports both encrypt and decrypt. The block sits between a segment-wide data stream and an external AES-128 block-encrypt core, reached through a request/acknowledge port. It holds the 128-bit feedback shift register and pre-computes the keystream for the next segment so the stream path sees a single-cycle XOR.

---
 rtl/cfb_stream_engine.sv | 184 ++++++++++++++++++
 tb/tb_cfb_stream_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfb_stream_engine.sv
// -----------------------------------------------------------------------------
// cfb_stream_engine
//
// AES-128 cipher-feedback (CFB-s) stream engine. Holds the 128-bit feedback
// shift register, asks an external AES block-encrypt core for the keystream of
// the next segment ahead of time, and then combines each input segment with
// that keystream in a single cycle. Encrypt and decrypt are both supported;
// the feedback is always the ciphertext segment.
//
// Parameters
//   SEG_W      segment width in bits (8, 16, 32, 64 or 128)
//   CNT_W      width of the delivered-segment counter
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   key                      cipher key, passed straight through to aes_key
//   iv, decrypt, iv_load     IV / mode load pulse; restarts the stream
//   in_valid, in_ready, din  input segment handshake
//   out_valid, out_ready,
//   dout                     registered output segment handshake
//   aes_req, aes_key,
//   aes_in, aes_ack, aes_out request/acknowledge port to the AES core
//   seg_count                segments delivered since the last reload
//   busy                     high whenever an IV has been loaded
// -----------------------------------------------------------------------------
module cfb_stream_engine #(
  parameter int unsigned SEG_W = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic             decrypt,
  input  logic             iv_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG_W-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEG_W-1:0] dout,
  output logic             aes_req,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_in,
  input  logic             aes_ack,
  input  logic [127:0]     aes_out,
  output logic [CNT_W-1:0] seg_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    StNoIv   = 2'd0,
    StGen    = 2'd1,
    StWaitIn = 2'd2,
    StOut    = 2'd3
  } state_e;

  state_e             state_q;
  logic [127:0]       shift_q;
  logic [SEG_W-1:0]   ks_q;         // only the keystream bits a segment consumes
  logic               mode_q;       // 1 = decrypt
  logic [SEG_W-1:0]   dout_q;
  logic [CNT_W-1:0]   seg_count_q;

  // An iv_load that cannot be applied at once (GEN keeps aes_in frozen, OUT
  // must finish delivering) is parked here, together with its IV and mode,
  // because iv/decrypt are only guaranteed valid during the pulse.
  logic               pending_iv_q;
  logic [127:0]       pend_iv_q;
  logic               pend_dec_q;

  logic [SEG_W-1:0]   enc_seg;
  logic [SEG_W-1:0]   ct_seg;
  logic [127:0]       shift_fb;
  logic [127:0]       rl_iv;
  logic               rl_dec;

  assign enc_seg = ks_q ^ din;
  // Feedback is always ciphertext: the result when encrypting, the input when
  // decrypting.
  assign ct_seg  = mode_q ? din : enc_seg;

  // A fresh iv_load pulse wins over a parked one.
  assign rl_iv  = iv_load ? iv : pend_iv_q;
  assign rl_dec = iv_load ? decrypt : pend_dec_q;

  if (SEG_W == 128) begin : g_full_seg
    assign shift_fb = ct_seg;
  end else begin : g_part_seg
    assign shift_fb = {shift_q[127-SEG_W:0], ct_seg};

    // Low keystream bits are never combined with data.
    logic unused_ks_bits;
    assign unused_ks_bits = ^aes_out[127-SEG_W:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNoIv;
      shift_q      <= '0;
      ks_q         <= '0;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      seg_count_q  <= '0;
      pending_iv_q <= 1'b0;
      pend_iv_q    <= '0;
      pend_dec_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StNoIv: begin
          if (iv_load) begin
            shift_q     <= iv;
            mode_q      <= decrypt;
            seg_count_q <= '0;
            state_q     <= StGen;
          end
        end

        StGen: begin
          if (aes_ack) begin
            if (iv_load || pending_iv_q) begin
              // Result belongs to the old IV: drop it and request again.
              shift_q      <= rl_iv;
              mode_q       <= rl_dec;
              seg_count_q  <= '0;
              pending_iv_q <= 1'b0;
            end else begin
              ks_q    <= aes_out[127 -: SEG_W];
              state_q <= StWaitIn;
            end
          end else if (iv_load) begin
            pending_iv_q <= 1'b1;
            pend_iv_q    <= iv;
            pend_dec_q   <= decrypt;
          end
        end

        StWaitIn: begin
          if (iv_load) begin
            shift_q     <= iv;
            mode_q      <= decrypt;
            seg_count_q <= '0;
            state_q     <= StGen;
          end else if (in_valid) begin
            dout_q  <= enc_seg;
            shift_q <= shift_fb;
            state_q <= StOut;
          end
        end

        StOut: begin
          if (out_ready) begin
            state_q <= StGen;
            if (iv_load || pending_iv_q) begin
              // Held segment still goes out, but the feedback is replaced.
              shift_q      <= rl_iv;
              mode_q       <= rl_dec;
              seg_count_q  <= '0;
              pending_iv_q <= 1'b0;
            end else begin
              seg_count_q <= seg_count_q + CNT_W'(1);
            end
          end else if (iv_load) begin
            pending_iv_q <= 1'b1;
            pend_iv_q    <= iv;
            pend_dec_q   <= decrypt;
          end
        end

        default: state_q <= StNoIv;
      endcase
    end
  end

  assign in_ready  = (state_q == StWaitIn);
  assign out_valid = (state_q == StOut);
  assign aes_req   = (state_q == StGen);
  assign busy      = (state_q != StNoIv);
  assign dout      = dout_q;
  assign aes_in    = shift_q;
  assign aes_key   = key;
  assign seg_count = seg_count_q;

endmodule

// File: tb/tb_cfb_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_cfb_stream_engine
//
// Directed bench for cfb_stream_engine. Three engines share one clock/reset:
// index 0 uses SEG_W=64 (directed vectors), index 1 SEG_W=8 and index 2
// SEG_W=128 (encrypt/decrypt round trips). Each has a cipher stub returning
// ~aes_in a few cycles after aes_req rises.
// -----------------------------------------------------------------------------
module tb_cfb_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] key;
  logic         stray_ack;

  logic         iv_load_a   [3];
  logic         dec_a       [3];
  logic         in_valid_a  [3];
  logic         out_ready_a [3];
  logic [127:0] din_a       [3];
  logic [127:0] iv_a        [3];

  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         aes_req_a   [3];
  logic         busy_a      [3];
  logic [127:0] dout_a      [3];
  logic [127:0] aes_in_a    [3];
  logic [127:0] aes_key_a   [3];
  logic [31:0]  seg_count_a [3];

  logic         ack_a       [3];
  logic [127:0] aes_out_a   [3];
  int           cnt_a       [3];

  int checks   = 0;
  int failures = 0;

  logic [127:0] pt_m [32];
  logic [127:0] ct_m [32];

  localparam logic [127:0] IV2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] IV3 = 128'hDEADBEEF00000000123456789ABCDEF0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 64 : ((g == 1) ? 8 : 128);
    logic [W-1:0] dout_w;

    cfb_stream_engine #(
      .SEG_W(W),
      .CNT_W(32)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key      (key),
      .iv       (iv_a[g]),
      .decrypt  (dec_a[g]),
      .iv_load  (iv_load_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .din      (din_a[g][W-1:0]),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .dout     (dout_w),
      .aes_req  (aes_req_a[g]),
      .aes_key  (aes_key_a[g]),
      .aes_in   (aes_in_a[g]),
      .aes_ack  (ack_a[g] | ((g == 0) && stray_ack)),
      .aes_out  (aes_out_a[g]),
      .seg_count(seg_count_a[g]),
      .busy     (busy_a[g])
    );

    assign dout_a[g] = 128'(dout_w);
  end

  // Cipher stub: E(k, x) = ~x, ack a few cycles into each request.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ack_a[i]     <= 1'b0;
        cnt_a[i]     <= 0;
        aes_out_a[i] <= '0;
      end else if (ack_a[i]) begin
        ack_a[i] <= 1'b0;
        cnt_a[i] <= 0;
      end else if (aes_req_a[i]) begin
        if (cnt_a[i] == 2) begin
          ack_a[i]     <= 1'b1;
          aes_out_a[i] <= ~aes_in_a[i];
        end else begin
          cnt_a[i] <= cnt_a[i] + 1;
        end
      end else begin
        cnt_a[i] <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (in_ready_a[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 128'(in_ready_a[i]), 128'd1);
  endtask

  task automatic load_iv(input int i, input logic [127:0] v, input logic d);
    iv_a[i]      = v;
    dec_a[i]     = d;
    iv_load_a[i] = 1'b1;
    @(negedge clk);
    iv_load_a[i] = 1'b0;
  endtask

  // One full segment: wait for in_ready, present din, capture dout, accept it.
  task automatic xfer(input int i, input logic [127:0] d, output logic [127:0] r);
    wait_ready(i);
    in_valid_a[i] = 1'b1;
    din_a[i]      = d;
    @(negedge clk);
    in_valid_a[i] = 1'b0;
    chk("xfer_out_valid", 128'(out_valid_a[i]), 128'd1);
    r = dout_a[i];
    out_ready_a[i] = 1'b1;
    @(negedge clk);
    out_ready_a[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    logic [127:0] a0;
    logic [127:0] ivr;
    logic [127:0] mask;
    logic         ok;
    int           n;

    rst_n     = 1'b0;
    stray_ack = 1'b0;
    key       = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    for (int i = 0; i < 3; i++) begin
      iv_load_a[i]   = 1'b0;
      dec_a[i]       = 1'b0;
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      din_a[i]       = '0;
      iv_a[i]        = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  128'(in_ready_a[0]),  128'd0);
    chk("rst_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("rst_dout",      dout_a[0],            128'd0);
    chk("rst_aes_req",   128'(aes_req_a[0]),   128'd0);
    chk("rst_aes_in",    aes_in_a[0],          128'd0);
    chk("rst_seg_count", 128'(seg_count_a[0]), 128'd0);
    chk("rst_busy",      128'(busy_a[0]),      128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("aes_key_passthru", aes_key_a[0], key);

    // NOIV ignores input
    in_valid_a[0] = 1'b1;
    din_a[0]      = 128'h55;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    chk("noiv_in_ready",  128'(in_ready_a[0]),  128'd0);
    chk("noiv_out_valid", 128'(out_valid_a[0]), 128'd0);

    // Encrypt, iv = 0
    load_iv(0, 128'd0, 1'b0);
    chk("load_aes_req", 128'(aes_req_a[0]), 128'd1);
    chk("load_busy",    128'(busy_a[0]),    128'd1);
    chk("load_aes_in",  aes_in_a[0],        128'd0);
    xfer(0, 128'h0123456789ABCDEF, r);
    chk("enc_seg0", r, 128'hFEDCBA9876543210);
    xfer(0, 128'h0, r);
    chk("enc_seg1", r, 128'hFFFFFFFFFFFFFFFF);
    chk("enc_count2", 128'(seg_count_a[0]), 128'd2);
    chk("enc_shift", aes_in_a[0], 128'hFEDCBA9876543210_FFFFFFFFFFFFFFFF);

    // Backpressure
    wait_ready(0);
    in_valid_a[0] = 1'b1;
    din_a[0]      = 128'hA5A5A5A5A5A5A5A5;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    chk("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
    chk("bp_dout", dout_a[0], 128'hA486E0C22C0E684A);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dout_a[0] !== 128'hA486E0C22C0E684A || aes_req_a[0] !== 1'b0 ||
          in_ready_a[0] !== 1'b0 || out_valid_a[0] !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold", 128'(ok), 128'd1);
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("bp_released", 128'(out_valid_a[0]), 128'd0);
    chk("bp_count3",   128'(seg_count_a[0]), 128'd3);
    chk("bp_next_req", 128'(aes_req_a[0]),   128'd1);

    // iv_load one cycle after aes_req rises
    a0 = aes_in_a[0];
    chk("gen_old_aes_in", a0, 128'hFFFFFFFFFFFFFFFF_A486E0C22C0E684A);
    iv_a[0]      = IV2;
    dec_a[0]     = 1'b0;
    iv_load_a[0] = 1'b1;
    @(negedge clk);
    iv_load_a[0] = 1'b0;
    iv_a[0]      = '1;
    ok = 1'b1;
    n  = 0;
    while (ack_a[0] !== 1'b1 && n < 50) begin
      if (aes_in_a[0] !== a0 || aes_req_a[0] !== 1'b1) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("gen_ack_seen",     128'(ack_a[0]), 128'd1);
    chk("gen_aes_in_stable", 128'(ok),      128'd1);
    chk("gen_aes_in_at_ack", aes_in_a[0],   128'hFFFFFFFFFFFFFFFF_A486E0C22C0E684A);
    @(negedge clk);
    chk("gen_discard_in_ready", 128'(in_ready_a[0]),  128'd0);
    chk("gen_rereq",            128'(aes_req_a[0]),   128'd1);
    chk("gen_new_aes_in",       aes_in_a[0],          IV2);
    chk("gen_count0",           128'(seg_count_a[0]), 128'd0);
    xfer(0, 128'hFFFF0000FFFF0000, r);
    chk("gen_new_ks_dout", r, 128'h0011DDCC44559988);

    // iv_load while the output is held
    wait_ready(0);
    in_valid_a[0] = 1'b1;
    din_a[0]      = 128'h0;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    chk("out_dout", dout_a[0], 128'h7766554433221100);
    iv_a[0]      = IV3;
    iv_load_a[0] = 1'b1;
    @(negedge clk);
    iv_load_a[0] = 1'b0;
    iv_a[0]      = '1;
    chk("out_still_valid", 128'(out_valid_a[0]),  128'd1);
    chk("out_dout_held",   dout_a[0],             128'h7766554433221100);
    chk("out_count1",      128'(seg_count_a[0]),  128'd1);
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("out_delivered", 128'(out_valid_a[0]), 128'd0);
    chk("out_count0",    128'(seg_count_a[0]), 128'd0);
    chk("out_reload_iv", aes_in_a[0],          IV3);
    chk("out_req",       128'(aes_req_a[0]),   128'd1);

    // iv_load in WAIT_IN together with in_valid
    wait_ready(0);
    chk("wi_in_ready", 128'(in_ready_a[0]), 128'd1);
    in_valid_a[0] = 1'b1;
    din_a[0]      = 128'h1111;
    iv_a[0]       = 128'd0;
    dec_a[0]      = 1'b0;
    iv_load_a[0]  = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    iv_load_a[0]  = 1'b0;
    chk("wi_in_ready_drop", 128'(in_ready_a[0]),  128'd0);
    chk("wi_no_out",        128'(out_valid_a[0]), 128'd0);
    chk("wi_req",           128'(aes_req_a[0]),   128'd1);
    chk("wi_aes_in",        aes_in_a[0],          128'd0);
    xfer(0, 128'h0123456789ABCDEF, r);
    chk("wi_restart_dout", r, 128'hFEDCBA9876543210);
    chk("wi_count1", 128'(seg_count_a[0]), 128'd1);

    // Round trips at SEG_W = 8 and 128
    for (int i = 1; i < 3; i++) begin
      mask = (i == 1) ? 128'hFF : '1;
      ivr  = {$urandom, $urandom, $urandom, $urandom};
      load_iv(i, ivr, 1'b0);
      for (int k = 0; k < 32; k++) begin
        pt_m[k] = {$urandom, $urandom, $urandom, $urandom} & mask;
        xfer(i, pt_m[k], ct_m[k]);
      end
      load_iv(i, ivr, 1'b1);
      for (int k = 0; k < 32; k++) begin
        xfer(i, ct_m[k], r);
        chk($sformatf("rt_dut%0d_seg%0d", i, k), r, pt_m[k]);
      end
    end

    // Asynchronous reset while aes_req is high
    wait_ready(0);
    in_valid_a[0] = 1'b1;
    din_a[0]      = 128'h0;
    @(negedge clk);
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("ar_req_high", 128'(aes_req_a[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_in_ready",  128'(in_ready_a[0]),  128'd0);
    chk("ar_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("ar_dout",      dout_a[0],            128'd0);
    chk("ar_aes_req",   128'(aes_req_a[0]),   128'd0);
    chk("ar_aes_in",    aes_in_a[0],          128'd0);
    chk("ar_seg_count", 128'(seg_count_a[0]), 128'd0);
    chk("ar_busy",      128'(busy_a[0]),      128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy",     128'(busy_a[0]),     128'd0);
    chk("stray_in_ready", 128'(in_ready_a[0]), 128'd0);
    chk("stray_aes_req",  128'(aes_req_a[0]),  128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
